codec_sample_buffer: RTL
========================

// Module: codec_sample_buffer
// PURPOSE
//   Stereo sample FIFO directly upstream of the AC97 codec interface. Accepts {left,right}
//   16-bit PCM pairs from the wave/note generator with a valid/ready handshake. Presents one
//   pair per codec frame on pcm_left/pcm_right, advancing only on a rising edge of
//   playback_accept. Outputs are held constant between frames, so the codec never sees a
//   mid-frame change. Absorbs generator burstiness and counts underruns.
// PARAMETERS
//   DEPTH       16  FIFO entries (power of 2, >=2)
//   SAMPLE_W    16  bits per channel
//   UNDERRUN_ZERO 1 1: output 0/0 on underrun; 0: repeat last held pair
// PORTS
//   clk             in   1           system clock (same clock as the codec interface)
//   reset_n         in   1           asynchronous, active-low reset
//   in_left         in   SAMPLE_W    generator left sample
//   in_right        in   SAMPLE_W    generator right sample
//   in_valid        in   1           generator pair valid
//   in_ready        out  1           buffer can accept; push = in_valid & in_ready
//   flush           in   1           synchronous FIFO clear
//   playback_accept in   1           codec frame strobe (level, high ~half of each frame)
//   pcm_left        out  SAMPLE_W    to codec PCM_Playback_Left
//   pcm_right       out  SAMPLE_W    to codec PCM_Playback_Right
//   frame_tick      out  1           1-cycle pulse: a new pair is presented this cycle
//   fill_level      out  log2(DEPTH)+1  entries currently stored
//   underrun_count  out  16          saturating count of frames served while empty
// BEHAVIOUR
//   Reset (async, reset_n=0): pointers=0, fill_level=0, held pair=0, accept_q=0,
//     underrun_count=0. in_ready=1 and pcm_*=0 immediately after reset.
//   Frame detect: accept_q <= playback_accept each clk. frame_tick = playback_accept & ~accept_q.
//   Output path: next_pair = (fill_level!=0) ? head : (UNDERRUN_ZERO ? 0 : held).
//     pcm_* = frame_tick ? next_pair : held. This is a combinational lookahead in the tick
//     cycle only. On the clock edge ending the tick cycle: held <= next_pair.
//     Net effect: the new pair is stable across the codec's latch edge and for the whole frame.
//   Pop: on the frame_tick edge, if fill_level!=0, the head is removed (rd_ptr+1, wraps mod DEPTH).
//   Underrun: frame_tick with fill_level==0 -> no pop; underrun_count+1, saturating at 16'hFFFF.
//   Push: in_ready = (fill_level != DEPTH). On push, the pair is written at wr_ptr and wr_ptr+1 (wraps).
//     A push while full is impossible because in_ready=0. in_ready does not depend on a
//     same-cycle pop (no combinational path from playback_accept to in_ready).
//   Simultaneous push+pop: both occur; fill_level unchanged. A push into an empty FIFO in a
//     tick cycle is NOT forwarded: that tick is an underrun, and the pushed pair is served
//     next frame.
//   flush=1: pointers and fill_level cleared at the edge. A push or pop in the same cycle is
//     discarded. held and underrun_count are unchanged. A tick in the flush cycle still
//     presents next_pair computed from the pre-flush state.
//   fill_level is exact: +1 on push only, -1 on pop only.
//   Latency: a pair pushed into an empty FIFO appears on pcm_* at the first frame_tick at
//     least 1 cycle later.
// STRUCTURE
//   Shared include codec_defs.vh: SAMPLE_W default and the stereo pair width (2*SAMPLE_W),
//     used by both the generator and the codec interface.
//   Sub-module stereo_fifo_mem: DEPTH x 2*SAMPLE_W storage, pointers, fill_level, full/empty.
//     Write-first is not required: reads use the registered head only.
//   Top: edge detect, held register, output mux, underrun counter. Built on dffr/dffre flops.
// TESTING
//   1 Reset: hold reset_n=0 while toggling accept -> pcm_*=0, in_ready=1, fill_level=0,
//     underrun_count=0.
//   2 Push (1,2),(3,4),(5,6), then 3 accept rises -> pcm = (1,2),(3,4),(5,6) in order. Each
//     pair is stable from its tick cycle until the next tick; the codec model prints no errors.
//   3 Empty FIFO, 2 accept rises, UNDERRUN_ZERO=1 -> pcm=0/0, underrun_count=2. With
//     UNDERRUN_ZERO=0 and last pair (5,6) -> pcm stays (5,6).
//   4 Fill 16 pairs -> in_ready=0, fill_level=16. Push attempt ignored. Tick with in_valid=1
//     -> pop; in_ready=1 next cycle; fill_level=15 then 16.
//   5 fill_level=1, push (7,8) in the tick cycle -> head popped, (7,8) stored, fill_level stays 1.
//   6 reset_n pulsed low mid-stream with fill_level=5 -> all state cleared asynchronously, and
//     pcm_*=0 before the next clk edge. flush with fill_level=5 -> fill_level=0, pcm holds
//     the current pair.

Source files
------------

// File: rtl/codec_sample_buffer_pkg.sv
// Shared definitions for the codec sample buffer.
//   CODEC_SAMPLE_W : default bits per PCM channel
//   CODEC_PAIR_W   : width of one stereo pair {left, right}
//   UNDERRUN_W     : width of the underrun counter
//   sat_inc()      : saturating increment used by the underrun counter
package codec_sample_buffer_pkg;

  localparam int CODEC_SAMPLE_W = 16;
  localparam int CODEC_PAIR_W   = 2 * CODEC_SAMPLE_W;
  localparam int UNDERRUN_W     = 16;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (&v) ? v : v + UNDERRUN_W'(1);
  endfunction

endpackage

// File: rtl/codec_sample_buffer_fifo.sv
// Stereo pair storage for the codec sample buffer.
// Holds DEPTH entries of PAIR_W bits with read/write pointers and an exact fill count.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               synchronous clear of pointers and fill count (wins over push/pop)
//   push, wr_data       write one pair at the tail (caller guarantees not full)
//   pop                 remove the head (caller guarantees not empty)
//   rd_data             current head pair (valid when !empty)
//   fill_level          entries currently stored, 0..DEPTH
//   full, empty         fill_level == DEPTH / fill_level == 0
module codec_sample_buffer_fifo
  import codec_sample_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PAIR_W = CODEC_PAIR_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [PAIR_W-1:0] wr_data,
  input  logic              pop,
  output logic [PAIR_W-1:0] rd_data,
  output logic [AW:0]       fill_level,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [PAIR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q,   fill_d;

  // A flush cancels any push or pop issued in the same cycle.
  logic do_push;
  logic do_pop;
  assign do_push = push & ~flush;
  assign do_pop  = pop  & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill_d = fill_q + (AW+1)'(1);
        2'b01:   fill_d = fill_q - (AW+1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage carries no reset; stale contents are never observed because reads
  // are only used when the fill count says the head is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign fill_level = fill_q;
  assign full       = (fill_q == LVL_FULL);
  assign empty      = (fill_q == '0);

endmodule

// File: rtl/codec_sample_buffer.sv
// Stereo sample FIFO feeding the AC97 codec interface.
// Accepts {left,right} pairs with valid/ready and presents one pair per codec
// frame, advancing on each rising edge of playback_accept. Outputs are held
// between frames; frames served while empty are counted as underruns.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   in_left/in_right/in_valid generator pair and its valid
//   in_ready                  buffer can accept (not full)
//   flush                     synchronous clear of buffered pairs
//   playback_accept           codec frame strobe (level)
//   pcm_left/pcm_right        pair presented to the codec
//   frame_tick                1-cycle pulse when a new pair is presented
//   fill_level                entries currently stored
//   underrun_count            saturating count of frames served while empty
module codec_sample_buffer
  import codec_sample_buffer_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int SAMPLE_W      = CODEC_SAMPLE_W,
  parameter bit UNDERRUN_ZERO = 1'b1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SAMPLE_W-1:0]   in_left,
  input  logic [SAMPLE_W-1:0]   in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  playback_accept,
  output logic [SAMPLE_W-1:0]   pcm_left,
  output logic [SAMPLE_W-1:0]   pcm_right,
  output logic                  frame_tick,
  output logic [AW:0]           fill_level,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  localparam int PAIR_W = 2 * SAMPLE_W;

  logic                  accept_q;
  logic [PAIR_W-1:0]     held_q,     held_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;

  logic [PAIR_W-1:0] head_pair;
  logic [PAIR_W-1:0] next_pair;
  logic [PAIR_W-1:0] out_pair;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign frame_tick = playback_accept & ~accept_q;

  // in_ready is purely registered state; a pop in this cycle frees a slot
  // only from the next cycle on.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & ~fifo_full;
  // A same-cycle push into an empty FIFO is not forwarded: the tick underruns.
  assign pop      = frame_tick & ~fifo_empty;

  codec_sample_buffer_fifo #(
    .DEPTH  (DEPTH),
    .PAIR_W (PAIR_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .push       (push),
    .wr_data    ({in_left, in_right}),
    .pop        (pop),
    .rd_data    (head_pair),
    .fill_level (fill_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    if (!fifo_empty)        next_pair = head_pair;
    else if (UNDERRUN_ZERO) next_pair = '0;
    else                    next_pair = held_q;

    // Lookahead only during the tick cycle; the held register takes over from
    // the following cycle, so the pair is stable for the whole frame.
    out_pair   = frame_tick ? next_pair : held_q;
    held_d     = out_pair;
    underrun_d = (frame_tick && fifo_empty) ? sat_inc(underrun_q) : underrun_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accept_q   <= 1'b0;
      held_q     <= '0;
      underrun_q <= '0;
    end else begin
      accept_q   <= playback_accept;
      held_q     <= held_d;
      underrun_q <= underrun_d;
    end
  end

  assign pcm_left       = out_pair[PAIR_W-1:SAMPLE_W];
  assign pcm_right      = out_pair[SAMPLE_W-1:0];
  assign underrun_count = underrun_q;

endmodule
